// File: rtl/bot_seq_pkg.sv
// ---------------------------------------------------------------------------
// bot_seq_pkg
// Shared types and constants for the Rojobot timed motion-command sequencer.
//   TICK_W        width of a command's duration field (bot update ticks)
//   BOT_DEPTH     default command FIFO depth
//   BOT_STOP_CODE default MotCtl value meaning "both motors stopped"
//   state_t       sequencer FSM states
//   bot_cmd_t     one queued command {motctl, ticks}
// ---------------------------------------------------------------------------
package bot_seq_pkg;

    localparam int         TICK_W        = 16;
    localparam int         BOT_DEPTH     = 8;
    localparam logic [7:0] BOT_STOP_CODE = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    typedef struct packed {
        logic [7:0]        motctl;
        logic [TICK_W-1:0] ticks;
    } bot_cmd_t;

endpackage

// File: rtl/bot_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------
// bot_cmd_sequencer_if
// Command push handshake between the CPU register path and the sequencer.
//   i_cmd_valid   push request (from the CPU side)
//   o_cmd_ready   sequencer can accept the command this cycle
//   i_cmd_motctl  MotCtl value of the command
//   i_cmd_ticks   duration of the command in bot update ticks
// Modports: master = CPU/register side, slave = sequencer.
// ---------------------------------------------------------------------------
interface bot_cmd_sequencer_if;
    import bot_seq_pkg::*;

    logic              i_cmd_valid;
    logic              o_cmd_ready;
    logic [7:0]        i_cmd_motctl;
    logic [TICK_W-1:0] i_cmd_ticks;

    modport master (
        output i_cmd_valid,
        output i_cmd_motctl,
        output i_cmd_ticks,
        input  o_cmd_ready
    );

    modport slave (
        input  i_cmd_valid,
        input  i_cmd_motctl,
        input  i_cmd_ticks,
        output o_cmd_ready
    );

endinterface

// File: rtl/bot_cmd_fifo.sv
// ---------------------------------------------------------------------------
// bot_cmd_fifo
// Synchronous command FIFO, no fall-through: the head entry is readable
// combinationally, a pop advances it on the next edge.
//   clk, rst   clock, synchronous active-high reset
//   i_push     write i_data (ignored when full)
//   i_pop      discard head entry (ignored when empty)
//   i_flush    empty the FIFO on the next edge (wins over push/pop)
//   i_data     entry to write
//   o_data     current head entry
//   o_level    occupancy, 0..DEPTH
//   o_full     occupancy == DEPTH
//   o_empty    occupancy == 0
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module bot_cmd_fifo
    import bot_seq_pkg::*;
#(
    parameter int DEPTH = BOT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  bot_cmd_t               i_data,
    output bot_cmd_t               o_data,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]     LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

    bot_cmd_t      r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_level;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_level == LVL_FULL);
    assign o_empty = (r_level == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_data  = r_mem[r_rdPtr];
    assign o_level = r_level;

    // Storage has no reset; only the pointers and level define validity.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop keeps the level.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/bot_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// bot_cmd_sequencer
// Timed motion-command scheduler for the Rojobot (clk_75 domain). Queued
// {MotCtl, duration} commands are driven onto MotCtl_in for the programmed
// number of bot update ticks (rising edges of upd_sysregs); each finished
// command forces STOP, raises a sticky completion interrupt and the next
// queued command starts.
//   clk, rst        clock, synchronous active-high reset
//   cmdBus          command push handshake (slave side)
//   i_upd_sysregs   rojobot upd_sysregs level
//   i_int_ack       interrupt acknowledge pulse
//   i_abort         flush all commands and stop on the next edge
//   o_motctl        MotCtl_in to rojobot31_0
//   o_busy          a command is being driven
//   o_int           sticky completion interrupt
//   o_level         FIFO occupancy
//   o_done_cnt      completed commands, saturating at 255
// Optional build macro BOT_CMD_PROX_STOP_EN adds i_sensors, i_stop_mask and
// o_fault: a masked sensor hit while running acts as an abort, sets the
// sticky o_fault and raises o_int.
// ---------------------------------------------------------------------------
module bot_cmd_sequencer
    import bot_seq_pkg::*;
#(
    parameter int         DEPTH     = BOT_DEPTH,
    parameter logic [7:0] STOP_CODE = BOT_STOP_CODE
) (
    input  logic                   clk,
    input  logic                   rst,
    bot_cmd_sequencer_if.slave     cmdBus,
    input  logic                   i_upd_sysregs,
    input  logic                   i_int_ack,
    input  logic                   i_abort,
    output logic [7:0]             o_motctl,
    output logic                   o_busy,
    output logic                   o_int,
    output logic [$clog2(DEPTH):0] o_level,
    output logic [7:0]             o_done_cnt
`ifdef BOT_CMD_PROX_STOP_EN
    ,
    input  logic [7:0]             i_sensors,
    input  logic [7:0]             i_stop_mask,
    output logic                   o_fault
`endif
);

    localparam logic [TICK_W-1:0] CNT_ONE = TICK_W'(1);

    state_t            r_state;
    state_t            w_nextState;
    bot_cmd_t          r_cmd;
    logic [TICK_W-1:0] r_cnt;
    logic              r_updQ;
    logic              r_int;
    logic [7:0]        r_doneCnt;
    logic              w_tick;
    logic              w_proxHit;
    logic              w_abort;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_doneEvt;
    bot_cmd_t          w_pushData;
    bot_cmd_t          w_head;

    assign w_tick = i_upd_sysregs & ~r_updQ;

`ifdef BOT_CMD_PROX_STOP_EN
    assign w_proxHit = (r_state == RUN) && ((i_sensors & i_stop_mask) != 8'h00);
`else
    assign w_proxHit = 1'b0;
`endif

    // A proximity stop is handled exactly like a CPU abort.
    assign w_abort            = i_abort | w_proxHit;
    assign cmdBus.o_cmd_ready = ~w_full & ~w_abort;
    assign w_push             = cmdBus.i_cmd_valid & cmdBus.o_cmd_ready;
    assign w_pop              = (r_state == IDLE) & ~w_empty & ~w_abort;
    assign w_pushData         = '{motctl: cmdBus.i_cmd_motctl, ticks: cmdBus.i_cmd_ticks};

    bot_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_abort),
        .i_data  (w_pushData),
        .o_data  (w_head),
        .o_level (o_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next state; abort overrides everything and returns to IDLE.
    always_comb begin
        w_nextState = r_state;
        if (w_abort) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (!w_empty) w_nextState = LOAD;
                LOAD:    w_nextState = (r_cmd.ticks == '0) ? DONE : RUN;
                RUN:     if (w_tick && (r_cnt == CNT_ONE)) w_nextState = DONE;
                DONE:    w_nextState = IDLE;
                default: w_nextState = IDLE;
            endcase
        end
    end

    // FSM outputs; the motor is only driven in RUN, so a zero-tick command
    // never leaves STOP.
    always_comb begin
        o_motctl  = STOP_CODE;
        o_busy    = 1'b0;
        w_doneEvt = 1'b0;
        case (r_state)
            RUN: begin
                o_motctl = r_cmd.motctl;
                o_busy   = 1'b1;
            end
            DONE:    w_doneEvt = ~w_abort;
            default: ;
        endcase
    end

    // Command datapath: the head entry is captured on the pop edge, the
    // down-counter is loaded in LOAD and only counts ticks seen in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd  <= '0;
            r_cnt  <= '0;
            r_updQ <= 1'b0;
        end else begin
            r_updQ <= i_upd_sysregs;
            if (w_pop) begin
                r_cmd <= w_head;
            end
            if (w_abort) begin
                r_cnt <= '0;
            end else if (r_state == LOAD) begin
                r_cnt <= r_cmd.ticks;
            end else if ((r_state == RUN) && w_tick) begin
                r_cnt <= r_cnt - CNT_ONE;
            end
        end
    end

    // Completion bookkeeping; a set in the same cycle as an ack wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_int     <= 1'b0;
            r_doneCnt <= 8'h00;
        end else begin
            if (w_doneEvt || w_proxHit) begin
                r_int <= 1'b1;
            end else if (i_int_ack) begin
                r_int <= 1'b0;
            end
            if (w_doneEvt && (r_doneCnt != 8'hFF)) begin
                r_doneCnt <= r_doneCnt + 8'd1;
            end
        end
    end

`ifdef BOT_CMD_PROX_STOP_EN
    logic r_fault;

    // Sticky proximity fault, cleared with the interrupt acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if (w_proxHit) begin
            r_fault <= 1'b1;
        end else if (i_int_ack) begin
            r_fault <= 1'b0;
        end
    end

    assign o_fault = r_fault;
`endif

    assign o_int      = r_int;
    assign o_done_cnt = r_doneCnt;

endmodule

// File: tb/tb_bot_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bot_cmd_sequencer
// Directed bench for bot_cmd_sequencer with a queue-based reference model
// compared every cycle, plus literal expectations at key points.
// ---------------------------------------------------------------------------
module tb_bot_cmd_sequencer;
    import bot_seq_pkg::*;

    localparam int         DEPTH  = 8;
    localparam logic [7:0] STOP_V = 8'h00;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              updSysregs = 1'b0;
    logic              intAck = 1'b0;
    logic              abortReq = 1'b0;
    logic [7:0]        motctl;
    logic              busy;
    logic              intr;
    logic [3:0]        level;
    logic [7:0]        doneCnt;
`ifdef BOT_CMD_PROX_STOP_EN
    logic [7:0]        sensors = 8'h00;
    logic [7:0]        stopMask = 8'h00;
    logic              fault;
`endif

    bot_cmd_sequencer_if cmdBus ();

    bot_cmd_sequencer #(
        .DEPTH     (DEPTH),
        .STOP_CODE (STOP_V)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmdBus        (cmdBus),
        .i_upd_sysregs (updSysregs),
        .i_int_ack     (intAck),
        .i_abort       (abortReq),
        .o_motctl      (motctl),
        .o_busy        (busy),
        .o_int         (intr),
        .o_level       (level),
        .o_done_cnt    (doneCnt)
`ifdef BOT_CMD_PROX_STOP_EN
        ,
        .i_sensors     (sensors),
        .i_stop_mask   (stopMask),
        .o_fault       (fault)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit checkEn = 1'b0;

    // Reference model: a queue of pending commands plus the command in hand.
    logic [7:0]  mQMot[$];
    logic [15:0] mQTicks[$];
    logic [7:0]  mCurMot = STOP_V;
    logic [15:0] mCurTicks = '0;
    int          mLeft = 0;
    bit          mLoading = 0;
    bit          mRunning = 0;
    bit          mFinishing = 0;
    bit          mUpdQ = 0;
    bit          mInt = 0;
    bit          mFault = 0;
    int          mDone = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit modelProx();
`ifdef BOT_CMD_PROX_STOP_EN
        return mRunning && ((sensors & stopMask) != 8'h00);
`else
        return 1'b0;
`endif
    endfunction

    task automatic modelStep();
        bit tick;
        bit prox;
        bit abortNow;
        bit pushNow;
        bit doneNow;
        if (rst) begin
            mQMot.delete();
            mQTicks.delete();
            mCurMot = STOP_V;
            mCurTicks = '0;
            mLeft = 0;
            mLoading = 0;
            mRunning = 0;
            mFinishing = 0;
            mUpdQ = 0;
            mInt = 0;
            mFault = 0;
            mDone = 0;
            return;
        end
        tick = updSysregs && !mUpdQ;
        mUpdQ = updSysregs;
        prox = modelProx();
        abortNow = abortReq || prox;
        pushNow = cmdBus.i_cmd_valid && (mQMot.size() < DEPTH) && !abortNow;
        doneNow = 0;
        if (abortNow) begin
            mQMot.delete();
            mQTicks.delete();
            mLoading = 0;
            mRunning = 0;
            mFinishing = 0;
            mLeft = 0;
        end else if (mFinishing) begin
            doneNow = 1;
            mFinishing = 0;
        end else if (mRunning) begin
            if (tick) begin
                if (mLeft == 1) begin
                    mRunning = 0;
                    mFinishing = 1;
                end
                mLeft--;
            end
        end else if (mLoading) begin
            mLoading = 0;
            if (mCurTicks == 0) begin
                mFinishing = 1;
            end else begin
                mRunning = 1;
                mLeft = int'(mCurTicks);
            end
        end else if (mQMot.size() > 0) begin
            mCurMot = mQMot.pop_front();
            mCurTicks = mQTicks.pop_front();
            mLoading = 1;
        end
        if (pushNow) begin
            mQMot.push_back(cmdBus.i_cmd_motctl);
            mQTicks.push_back(cmdBus.i_cmd_ticks);
        end
        if (doneNow || prox) mInt = 1;
        else if (intAck) mInt = 0;
        if (prox) mFault = 1;
        else if (intAck) mFault = 0;
        if (doneNow && mDone < 255) mDone++;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            modelStep();
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (checkEn) begin
                checkOutput("motctl", 32'(motctl), 32'(mRunning ? mCurMot : STOP_V));
                checkOutput("busy", 32'(busy), 32'(mRunning));
                checkOutput("int", 32'(intr), 32'(mInt));
                checkOutput("level", 32'(level), 32'(mQMot.size()));
                checkOutput("donecnt", 32'(doneCnt), 32'(mDone));
                checkOutput("ready", 32'(cmdBus.o_cmd_ready),
                            32'((mQMot.size() < DEPTH) && !abortReq && !modelProx()));
`ifdef BOT_CMD_PROX_STOP_EN
                checkOutput("fault", 32'(fault), 32'(mFault));
`endif
            end
        end
    end

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One cycle of stimulus; pulse-type inputs return to 0 afterwards.
    task automatic applyStimulus(input bit valid, input logic [7:0] mot, input logic [15:0] ticks,
                                 input bit upd, input bit ack, input bit abrt);
        cmdBus.i_cmd_valid = valid;
        cmdBus.i_cmd_motctl = mot;
        cmdBus.i_cmd_ticks = ticks;
        updSysregs = upd;
        intAck = ack;
        abortReq = abrt;
        @(posedge clk);
        #1;
        cmdBus.i_cmd_valid = 1'b0;
        cmdBus.i_cmd_motctl = 8'h00;
        cmdBus.i_cmd_ticks = '0;
        updSysregs = 1'b0;
        intAck = 1'b0;
        abortReq = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        cmdBus.i_cmd_valid = 1'b0;
        cmdBus.i_cmd_motctl = 8'h00;
        cmdBus.i_cmd_ticks = '0;
        rst = 1'b1;
        stepCycles(3);
        rst = 1'b0;
        checkEn = 1'b1;

        $display("[TB] reset values");
        checkOutput("rst_motctl", 32'(motctl), 32'h00);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_int", 32'(intr), 32'd0);
        checkOutput("rst_level", 32'(level), 32'd0);
        checkOutput("rst_done", 32'(doneCnt), 32'd0);

        $display("[TB] single command, 3 ticks");
        applyStimulus(1, 8'h33, 16'd3, 0, 0, 0);
        checkOutput("t1_level", 32'(level), 32'd1);
        stepCycles(2);
        checkOutput("t1_latency", 32'(motctl), 32'h33);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            stepCycles(9);
            applyStimulus(0, 8'h00, 16'd0, 1, 0, 0);
            if (k < 3) checkOutput("t1_hold", 32'(motctl), 32'h33);
        end
        checkOutput("t1_stop", 32'(motctl), 32'h00);
        stepCycles(1);
        checkOutput("t1_int", 32'(intr), 32'd1);
        checkOutput("t1_done", 32'(doneCnt), 32'd1);
        applyStimulus(0, 8'h00, 16'd0, 0, 1, 0);
        checkOutput("t1_ack", 32'(intr), 32'd0);

        $display("[TB] fill FIFO while running");
        applyStimulus(1, 8'h11, 16'd5, 0, 0, 0);
        stepCycles(2);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1, 8'h40 + 8'(i), 16'd1, 0, 0, 0);
        end
        checkOutput("t2_level", 32'(level), 32'd8);
        checkOutput("t2_ready", 32'(cmdBus.o_cmd_ready), 32'd0);
        checkOutput("t2_motctl", 32'(motctl), 32'h11);
        for (int j = 0; j < 15; j++) begin
            applyStimulus(0, 8'h00, 16'd0, 1, 0, 0);
            stepCycles(4);
        end
        stepCycles(3);
        checkOutput("t2_drained", 32'(level), 32'd0);
        checkOutput("t2_done", 32'(doneCnt), 32'd10);
        applyStimulus(0, 8'h00, 16'd0, 0, 1, 0);

        $display("[TB] zero-tick command");
        applyStimulus(1, 8'h55, 16'd0, 0, 0, 0);
        stepCycles(3);
        checkOutput("t3_int", 32'(intr), 32'd1);
        checkOutput("t3_done", 32'(doneCnt), 32'd11);
        checkOutput("t3_motctl", 32'(motctl), 32'h00);
        applyStimulus(0, 8'h00, 16'd0, 0, 1, 0);
        checkOutput("t3_ack", 32'(intr), 32'd0);

        $display("[TB] ack coincident with completion");
        applyStimulus(1, 8'h56, 16'd0, 0, 0, 0);
        stepCycles(2);
        applyStimulus(0, 8'h00, 16'd0, 0, 1, 0);
        checkOutput("t4_setwins", 32'(intr), 32'd1);
        checkOutput("t4_done", 32'(doneCnt), 32'd12);
        applyStimulus(0, 8'h00, 16'd0, 0, 1, 0);
        checkOutput("t4_ack", 32'(intr), 32'd0);

        $display("[TB] abort during first command");
        applyStimulus(1, 8'h21, 16'd4, 0, 0, 0);
        applyStimulus(1, 8'h22, 16'd4, 0, 0, 0);
        applyStimulus(1, 8'h23, 16'd4, 0, 0, 0);
        checkOutput("t5_run", 32'(motctl), 32'h21);
        checkOutput("t5_level", 32'(level), 32'd2);
        applyStimulus(1, 8'h24, 16'd4, 0, 0, 1);
        checkOutput("t5_stop", 32'(motctl), 32'h00);
        checkOutput("t5_flush", 32'(level), 32'd0);
        checkOutput("t5_int", 32'(intr), 32'd0);
        checkOutput("t5_done", 32'(doneCnt), 32'd12);
        stepCycles(3);
        checkOutput("t5_idle", 32'(motctl), 32'h00);

        $display("[TB] reset mid-command");
        applyStimulus(1, 8'h66, 16'd5, 0, 0, 0);
        applyStimulus(1, 8'h67, 16'd5, 0, 0, 0);
        stepCycles(1);
        checkOutput("t6_run", 32'(motctl), 32'h66);
        rst = 1'b1;
        stepCycles(2);
        rst = 1'b0;
        checkOutput("t6_motctl", 32'(motctl), 32'h00);
        checkOutput("t6_level", 32'(level), 32'd0);
        checkOutput("t6_done", 32'(doneCnt), 32'd0);

        $display("[TB] done counter saturation");
        for (int i = 0; i < 260; i++) begin
            applyStimulus(1, 8'h70, 16'd0, 0, 0, 0);
            stepCycles(3);
        end
        stepCycles(2);
        checkOutput("t7_sat", 32'(doneCnt), 32'd255);
        applyStimulus(0, 8'h00, 16'd0, 0, 1, 0);

`ifdef BOT_CMD_PROX_STOP_EN
        $display("[TB] proximity stop");
        stopMask = 8'h0F;
        sensors = 8'h10;
        applyStimulus(1, 8'h77, 16'd9, 0, 0, 0);
        applyStimulus(1, 8'h78, 16'd9, 0, 0, 0);
        stepCycles(1);
        checkOutput("t8_masked", 32'(motctl), 32'h77);
        sensors = 8'h02;
        stepCycles(1);
        sensors = 8'h00;
        checkOutput("t8_stop", 32'(motctl), 32'h00);
        checkOutput("t8_fault", 32'(fault), 32'd1);
        checkOutput("t8_int", 32'(intr), 32'd1);
        checkOutput("t8_level", 32'(level), 32'd0);
        applyStimulus(0, 8'h00, 16'd0, 0, 1, 0);
        checkOutput("t8_clr", 32'(fault), 32'd0);
`endif

        stepCycles(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
